// File: rtl/decim_stream_packer.sv
// -----------------------------------------------------------------------------
// decim_stream_packer
//
// Buffers four-sample decimation beats (channel 0 pair, channel 1 pair) in a
// small FIFO. It then serializes each beat into one 2*NofBits word per enabled
// channel on a ready/valid stream. Beats arriving while the FIFO is full are
// dropped, and the sticky overflow flag records the loss.
//
// Ports:
//   clk_i          single clock
//   rst_i          asynchronous active-low reset
//   ch_en_i        channel enable mask, sampled with each input beat
//   clear_ovf_i    clears overflow_o on the next edge (a same-edge drop wins)
//   x0_i, x0z_i    channel 0 sample pair
//   x1_i, x1z_i    channel 1 sample pair
//   data_valid_i   input beat valid (no backpressure upstream)
//   m_data_o       output word {xNz, xN}
//   m_ch_o         channel index of m_data_o
//   m_valid_o      output word valid
//   m_ready_i      downstream accept
//   fill_level_o   FIFO entries held, excluding the output holding stage
//   overflow_o     sticky: an input beat was dropped
//   state_o        output stage state (0=EMPTY, 1=SEND0, 2=SEND1)
//
// Handshake: a word transfers on a rising edge where m_valid_o & m_ready_i.
// While m_valid_o=1 and m_ready_i=0, m_data_o/m_ch_o hold stable, and
// m_valid_o only drops after a transfer (or on reset).
// -----------------------------------------------------------------------------
module decim_stream_packer #(
   parameter int NofBits = 16,
   parameter int Depth   = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [1:0]                   ch_en_i,
   input  logic                         clear_ovf_i,
   input  logic [NofBits-1:0]           x0_i,
   input  logic [NofBits-1:0]           x0z_i,
   input  logic [NofBits-1:0]           x1_i,
   input  logic [NofBits-1:0]           x1z_i,
   input  logic                         data_valid_i,
   output logic [2*NofBits-1:0]         m_data_o,
   output logic                         m_ch_o,
   output logic                         m_valid_o,
   input  logic                         m_ready_i,
   output logic [$clog2(Depth+1)-1:0]   fill_level_o,
   output logic                         overflow_o,
   output logic [1:0]                   state_o
);

   localparam int AW = $clog2(Depth);
   localparam int CW = $clog2(Depth+1);
   localparam int DW = 4*NofBits;
   localparam int EW = 2 + DW;
   localparam logic [CW-1:0] FULL_CNT = CW'(Depth);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      SEND0 = 2'd1,
      SEND1 = 2'd2
   } state_t;

   state_t state, state_nxt;

   // FIFO storage: entry = {mask[1:0], x0, x0z, x1, x1z}
   logic [EW-1:0] mem [Depth];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [EW-1:0] head;

   logic beat_req, fifo_full, fifo_empty, push, drop, pop;

   // Holding stage: sample data of the popped entry plus whether channel 1
   // still has to be sent once channel 0 is done.
   logic [DW-1:0] hold_data;
   logic          hold_ch1;

   assign beat_req   = data_valid_i && (ch_en_i != 2'b00);
   assign fifo_full  = (count == FULL_CNT);
   assign fifo_empty = (count == '0);
   // A full FIFO drops the beat even if a pop frees a slot on the same edge.
   assign push       = beat_req && !fifo_full;
   assign drop       = beat_req && fifo_full;
   assign head       = mem[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= {ch_en_i, x0_i, x0z_i, x1_i, x1z_i};
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         overflow_o <= 1'b0;
      end else if (drop) begin
         overflow_o <= 1'b1;
      end else if (clear_ovf_i) begin
         overflow_o <= 1'b0;
      end
   end

   // Output stage FSM
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= EMPTY;
         hold_data <= '0;
         hold_ch1  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (pop) begin
            hold_data <= head[DW-1:0];
            hold_ch1  <= head[EW-1];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         EMPTY: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = head[EW-2] ? SEND0 : SEND1;
            end
         end
         SEND0: begin
            if (m_ready_i) begin
               if (hold_ch1) begin
                  state_nxt = SEND1;
               end else if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = head[EW-2] ? SEND0 : SEND1;
               end else begin
                  state_nxt = EMPTY;
               end
            end
         end
         SEND1: begin
            if (m_ready_i) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  state_nxt = head[EW-2] ? SEND0 : SEND1;
               end else begin
                  state_nxt = EMPTY;
               end
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // hold_data layout: [4N-1:3N]=x0, [3N-1:2N]=x0z, [2N-1:N]=x1, [N-1:0]=x1z
   always_comb begin
      m_data_o = '0;
      case (state)
         SEND0:   m_data_o = {hold_data[3*NofBits-1:2*NofBits], hold_data[4*NofBits-1:3*NofBits]};
         SEND1:   m_data_o = {hold_data[NofBits-1:0], hold_data[2*NofBits-1:NofBits]};
         default: m_data_o = '0;
      endcase
   end

   assign m_valid_o    = (state != EMPTY);
   assign m_ch_o       = (state == SEND1);
   assign fill_level_o = count;
   assign state_o      = state;

endmodule

// File: tb/tb_decim_stream_packer.sv
module tb_decim_stream_packer;

   logic        clk_i;
   logic        rst_i;
   logic [1:0]  ch_en_i;
   logic        clear_ovf_i;
   logic [15:0] x0_i, x0z_i, x1_i, x1z_i;
   logic        data_valid_i;
   logic [31:0] m_data_o;
   logic        m_ch_o;
   logic        m_valid_o;
   logic        m_ready_i;
   logic [4:0]  fill_level_o;
   logic        overflow_o;
   logic [1:0]  state_o;

   int errors = 0;
   int checks = 0;

   // Scoreboard: {ch, data}
   logic [32:0] exp_q[$];
   logic [32:0] exp_word;

   decim_stream_packer #(.NofBits(16), .Depth(16)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .ch_en_i      (ch_en_i),
      .clear_ovf_i  (clear_ovf_i),
      .x0_i         (x0_i),
      .x0z_i        (x0z_i),
      .x1_i         (x1_i),
      .x1z_i        (x1z_i),
      .data_valid_i (data_valid_i),
      .m_data_o     (m_data_o),
      .m_ch_o       (m_ch_o),
      .m_valid_o    (m_valid_o),
      .m_ready_i    (m_ready_i),
      .fill_level_o (fill_level_o),
      .overflow_o   (overflow_o),
      .state_o      (state_o)
   );

   // clock / reset
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Transfers happen at the next posedge; inputs only change at posedge+1.
   always @(negedge clk_i) begin
      if (rst_i && m_valid_o && m_ready_i) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_unexpected: got ch=%0d data=%h, required no word", m_ch_o, m_data_o);
         end else begin
            exp_word = exp_q.pop_front();
            if ({m_ch_o, m_data_o} !== exp_word) begin
               errors++;
               $display("FAIL scoreboard_word: got ch=%0d data=%h, required ch=%0d data=%h",
                        m_ch_o, m_data_o, exp_word[32], exp_word[31:0]);
            end
         end
      end
   end

   // driver tasks
   task automatic drive_beat(input logic [1:0] en, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d);
      ch_en_i      = en;
      x0_i         = a;
      x0z_i        = b;
      x1_i         = c;
      x1z_i        = d;
      data_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      data_valid_i = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(m_valid_o === 1'b0 && fill_level_o === 5'd0) && n < 200) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      checks++;
      if (n >= 200) begin
         errors++;
         $display("FAIL %s_timeout: got valid=%0d fill=%0d after 200 cycles, required idle", name, m_valid_o, fill_level_o);
      end
   endtask

   task automatic end_of_test(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_missing: got %0d words outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // tests
   task automatic test_reset();
      rst_i = 1'b0;
      cycles(3);
      checks++;
      if ({m_valid_o, m_ch_o, m_data_o, fill_level_o, overflow_o, state_o} !== 41'd0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%0d ch=%0d data=%h fill=%0d ovf=%0d state=%0d, required all 0",
                  m_valid_o, m_ch_o, m_data_o, fill_level_o, overflow_o, state_o);
      end
      rst_i = 1'b1;
      cycles(2);
   endtask

   task automatic test_single_beat();
      m_ready_i = 1'b1;
      exp_q.push_back({1'b0, 16'h0002, 16'h0001});
      exp_q.push_back({1'b1, 16'h7FFF, 16'h8000});
      drive_beat(2'b11, 16'h0001, 16'h0002, 16'h8000, 16'h7FFF);
      checks++;
      if (m_valid_o !== 1'b0 || fill_level_o !== 5'd1) begin
         errors++;
         $display("FAIL single_edge_k: got valid=%0d fill=%0d, required valid=0 fill=1", m_valid_o, fill_level_o);
      end
      cycles(1);
      checks++;
      if (m_valid_o !== 1'b1 || m_ch_o !== 1'b0 || m_data_o !== 32'h0002_0001 || fill_level_o !== 5'd0) begin
         errors++;
         $display("FAIL single_word0: got valid=%0d ch=%0d data=%h fill=%0d, required 1 0 00020001 0",
                  m_valid_o, m_ch_o, m_data_o, fill_level_o);
      end
      cycles(1);
      checks++;
      if (m_valid_o !== 1'b1 || m_ch_o !== 1'b1 || m_data_o !== 32'h7FFF_8000) begin
         errors++;
         $display("FAIL single_word1: got valid=%0d ch=%0d data=%h, required 1 1 7fff8000", m_valid_o, m_ch_o, m_data_o);
      end
      cycles(1);
      checks++;
      if (m_valid_o !== 1'b0 || fill_level_o !== 5'd0) begin
         errors++;
         $display("FAIL single_done: got valid=%0d fill=%0d, required 0 0", m_valid_o, fill_level_o);
      end
      end_of_test("single");
   endtask

   task automatic test_channel_masks();
      m_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({1'b1, 16'hF000 + 16'(i), 16'h0100 + 16'(i)});
      end
      for (int i = 0; i < 4; i++) begin
         drive_beat(2'b10, 16'hDEAD, 16'hBEEF, 16'h0100 + 16'(i), 16'hF000 + 16'(i));
      end
      wait_idle("ch1_only");
      end_of_test("ch1_only");
      for (int i = 0; i < 4; i++) begin
         drive_beat(2'b00, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      end
      cycles(3);
      checks++;
      if (m_valid_o !== 1'b0 || fill_level_o !== 5'd0 || overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL mask00: got valid=%0d fill=%0d ovf=%0d, required 0 0 0", m_valid_o, fill_level_o, overflow_o);
      end
   endtask

   task automatic test_mixed();
      m_ready_i = 1'b1;
      exp_q.push_back({1'b0, 16'hA001, 16'hA000});
      exp_q.push_back({1'b0, 16'hB001, 16'hB000});
      exp_q.push_back({1'b1, 16'hB003, 16'hB002});
      exp_q.push_back({1'b1, 16'hC003, 16'hC002});
      exp_q.push_back({1'b0, 16'hD001, 16'hD000});
      drive_beat(2'b01, 16'hA000, 16'hA001, 16'hA002, 16'hA003);
      drive_beat(2'b11, 16'hB000, 16'hB001, 16'hB002, 16'hB003);
      drive_beat(2'b10, 16'hC000, 16'hC001, 16'hC002, 16'hC003);
      drive_beat(2'b01, 16'hD000, 16'hD001, 16'hD002, 16'hD003);
      wait_idle("mixed");
      end_of_test("mixed");
   endtask

   task automatic test_overflow();
      int gaps;
      m_ready_i = 1'b0;
      for (int i = 0; i < 17; i++) begin
         exp_q.push_back({1'b0, 16'h2000 + 16'(i), 16'h1000 + 16'(i)});
      end
      for (int i = 0; i < 20; i++) begin
         drive_beat(2'b01, 16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'hAAAA, 16'h5555);
      end
      checks++;
      if (fill_level_o !== 5'd16 || overflow_o !== 1'b1 || m_valid_o !== 1'b1 || m_data_o !== 32'h2000_1000) begin
         errors++;
         $display("FAIL overflow_full: got fill=%0d ovf=%0d valid=%0d data=%h, required 16 1 1 20001000",
                  fill_level_o, overflow_o, m_valid_o, m_data_o);
      end
      m_ready_i = 1'b1;
      gaps = 0;
      for (int i = 0; i < 17; i++) begin
         if (m_valid_o !== 1'b1) gaps++;
         cycles(1);
      end
      checks++;
      if (gaps != 0 || m_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL overflow_drain: got gaps=%0d valid_after=%0d, required 0 0", gaps, m_valid_o);
      end
      end_of_test("overflow");
   endtask

   task automatic test_stall();
      m_ready_i = 1'b0;
      exp_q.push_back({1'b0, 16'h5A02, 16'h5A01});
      exp_q.push_back({1'b1, 16'h5A04, 16'h5A03});
      drive_beat(2'b11, 16'h5A01, 16'h5A02, 16'h5A03, 16'h5A04);
      cycles(1);
      checks++;
      if (m_valid_o !== 1'b1 || m_ch_o !== 1'b0 || m_data_o !== 32'h5A02_5A01) begin
         errors++;
         $display("FAIL stall_first: got valid=%0d ch=%0d data=%h, required 1 0 5a025a01", m_valid_o, m_ch_o, m_data_o);
      end
      m_ready_i = 1'b1;
      cycles(1);
      m_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycles(1);
         checks++;
         if (m_valid_o !== 1'b1 || m_ch_o !== 1'b1 || m_data_o !== 32'h5A04_5A03) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got valid=%0d ch=%0d data=%h, required 1 1 5a045a03",
                     i, m_valid_o, m_ch_o, m_data_o);
         end
      end
      m_ready_i = 1'b1;
      wait_idle("stall");
      end_of_test("stall");
   endtask

   task automatic test_ovf_clear();
      clear_ovf_i = 1'b1;
      cycles(1);
      clear_ovf_i = 1'b0;
      checks++;
      if (overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear_initial: got %0d, required 0", overflow_o);
      end
      m_ready_i = 1'b0;
      for (int i = 0; i < 17; i++) begin
         exp_q.push_back({1'b0, 16'h7700 + 16'(i), 16'h6600 + 16'(i)});
         drive_beat(2'b01, 16'h6600 + 16'(i), 16'h7700 + 16'(i), 16'h0000, 16'h0000);
      end
      checks++;
      if (fill_level_o !== 5'd16 || overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL ovf_fill: got fill=%0d ovf=%0d, required 16 0", fill_level_o, overflow_o);
      end
      clear_ovf_i = 1'b1;
      drive_beat(2'b01, 16'hEEEE, 16'hEEEE, 16'hEEEE, 16'hEEEE);
      clear_ovf_i = 1'b0;
      checks++;
      if (overflow_o !== 1'b1 || fill_level_o !== 5'd16) begin
         errors++;
         $display("FAIL ovf_drop_with_clear: got ovf=%0d fill=%0d, required 1 16", overflow_o, fill_level_o);
      end
      clear_ovf_i = 1'b1;
      cycles(1);
      clear_ovf_i = 1'b0;
      checks++;
      if (overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear_alone: got %0d, required 0", overflow_o);
      end
      m_ready_i = 1'b1;
      wait_idle("ovf_clear");
      end_of_test("ovf_clear");
   endtask

   task automatic test_reset_mid();
      m_ready_i = 1'b0;
      for (int i = 0; i < 9; i++) begin
         drive_beat(2'b11, 16'h0BAD, 16'h0BAD, 16'h0BAD, 16'h0BAD);
      end
      checks++;
      if (fill_level_o !== 5'd8 || m_valid_o !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_fill: got fill=%0d valid=%0d, required 8 1", fill_level_o, m_valid_o);
      end
      #2;
      rst_i = 1'b0;
      #1;
      checks++;
      if ({m_valid_o, m_ch_o, m_data_o, fill_level_o, overflow_o, state_o} !== 41'd0) begin
         errors++;
         $display("FAIL rstmid_async: got valid=%0d ch=%0d data=%h fill=%0d ovf=%0d state=%0d, required all 0",
                  m_valid_o, m_ch_o, m_data_o, fill_level_o, overflow_o, state_o);
      end
      cycles(2);
      rst_i = 1'b1;
      cycles(2);
      checks++;
      if (m_valid_o !== 1'b0 || fill_level_o !== 5'd0) begin
         errors++;
         $display("FAIL rstmid_release: got valid=%0d fill=%0d, required 0 0", m_valid_o, fill_level_o);
      end
      m_ready_i = 1'b1;
      exp_q.push_back({1'b0, 16'h00C2, 16'h00C1});
      exp_q.push_back({1'b1, 16'h00C4, 16'h00C3});
      drive_beat(2'b11, 16'h00C1, 16'h00C2, 16'h00C3, 16'h00C4);
      wait_idle("rstmid");
      end_of_test("rstmid");
   endtask

   initial begin
      rst_i        = 1'b0;
      ch_en_i      = 2'b00;
      clear_ovf_i  = 1'b0;
      x0_i         = '0;
      x0z_i        = '0;
      x1_i         = '0;
      x1z_i        = '0;
      data_valid_i = 1'b0;
      m_ready_i    = 1'b0;
      @(posedge clk_i);
      #1;
      test_reset();
      test_single_beat();
      test_channel_masks();
      test_mixed();
      test_overflow();
      test_stall();
      test_ovf_clear();
      test_reset_mid();
      cycles(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
